// File: rtl/simd_issue_sched_pkg.sv
// -----------------------------------------------------------------------------
// simd_issue_sched_pkg
// Shared types and helpers for the SIMD issue scheduler:
//   - SIMD_OP_W / SIMD_DATA_W : ALU operation and operand/result widths
//   - SIMD_SRC_W / SIMD_TAG_W : stored requester-index and tag widths
//   - simd_sched_ent_t        : result FIFO entry {data, src, tag}
//   - simd_rr_pick()          : round-robin first-valid search after a pointer
// -----------------------------------------------------------------------------
package simd_issue_sched_pkg;

    localparam int SIMD_OP_W    = 13;
    localparam int SIMD_DATA_W  = 68;
    localparam int SIMD_MAX_REQ = 4;
    // Wide enough for requester indices of up to SIMD_MAX_REQ requesters.
    localparam int SIMD_SRC_W   = 2;
    // Tag width carried through the FIFO; the scheduler's TAG_W must not exceed it.
    localparam int SIMD_TAG_W   = 9;

    typedef struct packed {
        logic [SIMD_DATA_W-1:0] data;
        logic [SIMD_SRC_W-1:0]  src;
        logic [SIMD_TAG_W-1:0]  tag;
    } simd_sched_ent_t;

    // Returns {found, index}: the first set bit of vld searching ptr+1, ptr+2, ...
    // modulo n_req. Bits of vld at or above n_req are ignored.
    function automatic logic [SIMD_SRC_W:0] simd_rr_pick(
        input logic [SIMD_MAX_REQ-1:0] vld,
        input logic [SIMD_SRC_W-1:0]   ptr,
        input int unsigned             n_req
    );
        logic [SIMD_SRC_W:0] pick;
        logic [31:0]         idx;
        pick = '0;
        for (int unsigned k = 1; k <= SIMD_MAX_REQ; k++) begin
            idx = (32'(ptr) + k) % n_req;
            if ((k <= n_req) && !pick[SIMD_SRC_W] && vld[idx[SIMD_SRC_W-1:0]]) begin
                pick = {1'b1, idx[SIMD_SRC_W-1:0]};
            end else begin
                pick = pick;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/simd_issue_sched_chk.sv
// -----------------------------------------------------------------------------
// simd_issue_sched_chk
// Assertion checker for simd_issue_sched (not part of the synthesized design).
//   - result FIFO never receives a push while full without a same-cycle pop
//   - req_rdy is one-hot or zero
// Ports: clk, rst, flush, push (tracker stage-out), pop (res_rdy),
//        fifo_cnt (FIFO occupancy), req_rdy (grant vector).
// -----------------------------------------------------------------------------
module simd_issue_sched_chk #(
    parameter int N_REQ      = 3,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 3
) (
    input logic             clk,
    input logic             rst,
    input logic             flush,
    input logic             push,
    input logic             pop,
    input logic [CNT_W-1:0] fifo_cnt,
    input logic [N_REQ-1:0] req_rdy
);

    // Sample the protocol properties on every active edge outside reset.
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(push && !flush && !pop && (fifo_cnt == CNT_W'(FIFO_DEPTH))));
            assert ($onehot0(req_rdy));
        end
    end

endmodule

// File: rtl/simd_res_fifo.sv
// -----------------------------------------------------------------------------
// simd_res_fifo
// In-order result FIFO for the SIMD issue scheduler. Push and pop may happen
// in the same cycle (also when full). A pop on an empty FIFO is ignored. clr
// empties the FIFO at the next edge and suppresses any same-cycle push/pop.
// The head entry is presented combinationally.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   clr             synchronous clear (flush)
//   push, push_ent  write request and entry
//   pop             read request (consumes head when head_vld)
//   head_vld        FIFO not empty
//   head_ent        oldest entry
//   cnt             current occupancy (0..DEPTH)
// -----------------------------------------------------------------------------
module simd_res_fifo
    import simd_issue_sched_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  simd_sched_ent_t  push_ent,
    input  logic             pop,
    output logic             head_vld,
    output simd_sched_ent_t  head_ent,
    output logic [CNT_W-1:0] cnt
);

    simd_sched_ent_t  mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Qualify push/pop and compute next pointers and occupancy.
    always_comb begin
        pop_ok_s  = pop && (cnt_q != '0) && !clr;
        // A push into a full FIFO is only legal when the head leaves in the same cycle.
        push_ok_s = push && !clr && ((cnt_q != CNT_W'(DEPTH)) || pop_ok_s);
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        cnt_d     = cnt_q;
        if (clr) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (pop_ok_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            if (push_ok_s) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   cnt_d = cnt_q + CNT_W'(1);
                2'b01:   cnt_d = cnt_q - CNT_W'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Entry storage; contents are only meaningful between rd_ptr and wr_ptr.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= push_ent;
        end
    end

    assign head_vld = (cnt_q != '0);
    assign head_ent = mem_q[rd_ptr_q];
    assign cnt      = cnt_q;

endmodule

// File: rtl/simd_issue_sched.sv
// -----------------------------------------------------------------------------
// simd_issue_sched
// Shares one fixed-latency SIMD integer ALU between N_REQ requesters.
// Round-robin grant (one per cycle), registered ALU issue, an in-flight
// tracker aligned with the ALU result, and a credit-protected result FIFO
// returning {data, requester, tag} in issue order.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   flush                    kill in-flight and buffered ops
//   req_vld/op/a/b/tag       per-requester operation
//   req_rdy                  one-hot grant (combinational)
//   alu_en/op/a/b            registered ALU issue; op/a/b hold when idle
//   alu_res                  ALU result, ALU_LAT cycles after alu_en
//   res_vld/rdy/data/src/tag result FIFO head and pop handshake
// Optional (macro SIMD_SCHED_STAT_EN):
//   stat_grant               saturating per-requester grant counters
//   stat_stall               saturating count of cycles with a request but no credit
// -----------------------------------------------------------------------------
module simd_issue_sched
    import simd_issue_sched_pkg::*;
#(
    parameter  int N_REQ      = 3,
    parameter  int TAG_W      = SIMD_TAG_W,
    parameter  int ALU_LAT    = 2,
    parameter  int FIFO_DEPTH = 4,
    localparam int SRC_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               flush,
    input  logic [N_REQ-1:0]                   req_vld,
    input  logic [N_REQ-1:0][SIMD_OP_W-1:0]    req_op,
    input  logic [N_REQ-1:0][SIMD_DATA_W-1:0]  req_a,
    input  logic [N_REQ-1:0][SIMD_DATA_W-1:0]  req_b,
    input  logic [N_REQ-1:0][TAG_W-1:0]        req_tag,
    output logic [N_REQ-1:0]                   req_rdy,
    output logic                               alu_en,
    output logic [SIMD_OP_W-1:0]               alu_op,
    output logic [SIMD_DATA_W-1:0]             alu_a,
    output logic [SIMD_DATA_W-1:0]             alu_b,
    input  logic [SIMD_DATA_W-1:0]             alu_res,
    output logic                               res_vld,
    input  logic                               res_rdy,
    output logic [SIMD_DATA_W-1:0]             res_data,
    output logic [SRC_W-1:0]                   res_src,
    output logic [TAG_W-1:0]                   res_tag
`ifdef SIMD_SCHED_STAT_EN
    ,
    output logic [N_REQ-1:0][31:0]             stat_grant,
    output logic [31:0]                        stat_stall
`endif
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int SUM_W = CNT_W + 1;

    logic [SRC_W-1:0]               rr_ptr_q, rr_ptr_d;
    logic [ALU_LAT:0]               trk_vld_q, trk_vld_d;
    logic [ALU_LAT:0][SRC_W-1:0]    trk_src_q, trk_src_d;
    logic [ALU_LAT:0][TAG_W-1:0]    trk_tag_q, trk_tag_d;
    logic                           alu_en_q, alu_en_d;
    logic [SIMD_OP_W-1:0]           alu_op_q, alu_op_d;
    logic [SIMD_DATA_W-1:0]         alu_a_q, alu_a_d;
    logic [SIMD_DATA_W-1:0]         alu_b_q, alu_b_d;

    logic [CNT_W-1:0]               fifo_cnt_s;
    logic [SUM_W-1:0]               inflight_s;
    logic [SUM_W-1:0]               used_s;
    logic                           issue_ok_s;
    logic [SIMD_MAX_REQ-1:0]        vld_ext_s;
    logic [SIMD_SRC_W:0]            pick_s;
    logic                           grant_vld_s;
    logic [SRC_W-1:0]               grant_idx_s;
    logic [N_REQ-1:0]               req_rdy_s;
    logic                           push_s;
    simd_sched_ent_t                push_ent_s;
    simd_sched_ent_t                head_ent_s;
    logic                           head_vld_s;

    // Credits: every op between acceptance and pop holds one FIFO slot.
    always_comb begin
        inflight_s = '0;
        for (int s = 0; s <= ALU_LAT; s++) begin
            if (trk_vld_q[s]) begin
                inflight_s = inflight_s + SUM_W'(1);
            end else begin
                inflight_s = inflight_s;
            end
        end
        used_s     = SUM_W'(fifo_cnt_s) + inflight_s;
        issue_ok_s = !rst && !flush && (used_s < SUM_W'(FIFO_DEPTH));
    end

    // Round-robin arbiter from the registered pointer.
    always_comb begin
        vld_ext_s              = '0;
        vld_ext_s[N_REQ-1:0]   = req_vld;
        pick_s                 = simd_rr_pick(vld_ext_s, SIMD_SRC_W'(rr_ptr_q), N_REQ);
        grant_vld_s            = issue_ok_s && pick_s[SIMD_SRC_W];
        grant_idx_s            = pick_s[SRC_W-1:0];
        req_rdy_s              = '0;
        if (grant_vld_s) begin
            req_rdy_s[grant_idx_s] = 1'b1;
        end else begin
            req_rdy_s = '0;
        end
    end

    // Next-state for pointer, ALU issue registers and tracker.
    always_comb begin
        if (grant_vld_s) begin
            rr_ptr_d = grant_idx_s;
            alu_op_d = req_op[grant_idx_s];
            alu_a_d  = req_a[grant_idx_s];
            alu_b_d  = req_b[grant_idx_s];
        end else begin
            rr_ptr_d = rr_ptr_q;
            alu_op_d = alu_op_q;
            alu_a_d  = alu_a_q;
            alu_b_d  = alu_b_q;
        end
        alu_en_d  = grant_vld_s;
        // Stage 0 is valid together with alu_en; stage ALU_LAT lines up with alu_res.
        trk_src_d = {trk_src_q[ALU_LAT-1:0], grant_idx_s};
        trk_tag_d = {trk_tag_q[ALU_LAT-1:0], req_tag[grant_idx_s]};
        if (flush) begin
            trk_vld_d = '0;
        end else begin
            trk_vld_d = {trk_vld_q[ALU_LAT-1:0], grant_vld_s};
        end
    end

    // Scheduler state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q  <= SRC_W'(N_REQ - 1);
            trk_vld_q <= '0;
            trk_src_q <= '0;
            trk_tag_q <= '0;
            alu_en_q  <= 1'b0;
            alu_op_q  <= '0;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            trk_vld_q <= trk_vld_d;
            trk_src_q <= trk_src_d;
            trk_tag_q <= trk_tag_d;
            alu_en_q  <= alu_en_d;
            alu_op_q  <= alu_op_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
        end
    end

    // Capture the ALU result of the op leaving the tracker.
    always_comb begin
        push_s          = trk_vld_q[ALU_LAT];
        push_ent_s.data = alu_res;
        push_ent_s.src  = SIMD_SRC_W'(trk_src_q[ALU_LAT]);
        push_ent_s.tag  = SIMD_TAG_W'(trk_tag_q[ALU_LAT]);
    end

    simd_res_fifo #(
        .DEPTH    (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .clr      (flush),
        .push     (push_s),
        .push_ent (push_ent_s),
        .pop      (res_rdy),
        .head_vld (head_vld_s),
        .head_ent (head_ent_s),
        .cnt      (fifo_cnt_s)
    );

    assign req_rdy  = req_rdy_s;
    assign alu_en   = alu_en_q;
    assign alu_op   = alu_op_q;
    assign alu_a    = alu_a_q;
    assign alu_b    = alu_b_q;
    assign res_vld  = head_vld_s;
    assign res_data = head_ent_s.data;
    assign res_src  = head_ent_s.src[SRC_W-1:0];
    assign res_tag  = head_ent_s.tag[TAG_W-1:0];

`ifdef SIMD_SCHED_STAT_EN
    logic [N_REQ-1:0][31:0] stat_grant_q, stat_grant_d;
    logic [31:0]            stat_stall_q, stat_stall_d;

    // Saturating statistics; flush does not clear them.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            if (req_rdy_s[i] && (stat_grant_q[i] != 32'hFFFF_FFFF)) begin
                stat_grant_d[i] = stat_grant_q[i] + 32'd1;
            end else begin
                stat_grant_d[i] = stat_grant_q[i];
            end
        end
        if ((|req_vld) && !issue_ok_s && (stat_stall_q != 32'hFFFF_FFFF)) begin
            stat_stall_d = stat_stall_q + 32'd1;
        end else begin
            stat_stall_d = stat_stall_q;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_grant_q <= '0;
            stat_stall_q <= '0;
        end else begin
            stat_grant_q <= stat_grant_d;
            stat_stall_q <= stat_stall_d;
        end
    end

    assign stat_grant = stat_grant_q;
    assign stat_stall = stat_stall_q;
`endif

endmodule

// File: tb/tb_simd_issue_sched.sv
// -----------------------------------------------------------------------------
// tb_simd_issue_sched
// Self-checking bench for simd_issue_sched. The bench plays the ALU and keeps
// a reference model: a single in-order queue of accepted, not-yet-popped ops,
// each with the cycle at which it becomes visible at the FIFO head.
// -----------------------------------------------------------------------------
module tb_simd_issue_sched;
    import simd_issue_sched_pkg::*;

    localparam int N     = 3;
    localparam int TW    = 9;
    localparam int LAT   = 2;
    localparam int DEPTH = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 flush;
    logic [N-1:0]         req_vld;
    logic [N-1:0][12:0]   req_op;
    logic [N-1:0][67:0]   req_a;
    logic [N-1:0][67:0]   req_b;
    logic [N-1:0][TW-1:0] req_tag;
    logic [N-1:0]         req_rdy;
    logic                 alu_en;
    logic [12:0]          alu_op;
    logic [67:0]          alu_a;
    logic [67:0]          alu_b;
    logic [67:0]          alu_res;
    logic                 res_vld;
    logic                 res_rdy;
    logic [67:0]          res_data;
    logic [1:0]           res_src;
    logic [TW-1:0]        res_tag;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    simd_issue_sched #(
        .N_REQ(N), .TAG_W(TW), .ALU_LAT(LAT), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_vld(req_vld), .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .req_tag(req_tag), .req_rdy(req_rdy),
        .alu_en(alu_en), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_res(alu_res),
        .res_vld(res_vld), .res_rdy(res_rdy), .res_data(res_data),
        .res_src(res_src), .res_tag(res_tag)
    );

    simd_issue_sched_chk #(
        .N_REQ(N), .FIFO_DEPTH(DEPTH), .CNT_W(3)
    ) u_chk (
        .clk(clk), .rst(rst), .flush(flush),
        .push(dut.push_s), .pop(res_rdy),
        .fifo_cnt(dut.fifo_cnt_s), .req_rdy(req_rdy)
    );

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [67:0] rnd68();
        logic [95:0] r;
        r = {$urandom(), $urandom(), $urandom()};
        return r[67:0];
    endfunction

    // The ALU operation the bench implements.
    function automatic logic [67:0] alu_fn(input logic [12:0] op, input logic [67:0] a, input logic [67:0] b);
        logic [67:0] s;
        s = a + b;
        return s ^ {55'd0, op};
    endfunction

    typedef struct {
        int          src;
        logic [8:0]  tag;
        logic [67:0] data;
        int          avail;
    } mop_t;

    mop_t        mq[$];
    int          m_ptr;
    logic        m_alu_en;
    logic [12:0] m_op;
    logic [67:0] m_a;
    logic [67:0] m_b;
    logic [67:0] alu_sched[int];
    int          cyc;
    bit          keep_ops;
    int          obs_log[$];
    int          obs_ngrant;

    // One clock cycle: drive, check against the model, advance the model.
    task automatic step(input logic [N-1:0] vld, input logic rdy, input logic fl, input logic rs);
        int   g;
        logic ok;
        logic exp_rv;
        logic [N-1:0] exp_rdy;
        rst = rs; flush = fl; req_vld = vld; res_rdy = rdy;
        if (!keep_ops) begin
            for (int i = 0; i < N; i++) begin
                req_op[i]  = 13'($urandom());
                req_a[i]   = rnd68();
                req_b[i]   = rnd68();
                req_tag[i] = 9'($urandom());
            end
        end
        alu_res = alu_sched.exists(cyc) ? alu_sched[cyc] : rnd68();
        #2;
        ok = !rs && !fl && (mq.size() < DEPTH);
        g  = -1;
        if (ok) begin
            for (int k = 1; k <= N; k++) begin
                int idx;
                idx = (m_ptr + k) % N;
                if (g < 0 && vld[idx]) g = idx;
            end
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        check_val("req_rdy", req_rdy, exp_rdy);
        exp_rv = (mq.size() > 0) && (cyc >= mq[0].avail);
        check_val("res_vld", res_vld, exp_rv);
        if (exp_rv && res_vld) begin
            check_val("res_src", res_src, mq[0].src);
            check_val("res_tag", res_tag, mq[0].tag);
            check_val("res_data", res_data, mq[0].data);
        end
        check_val("alu_en", alu_en, m_alu_en);
        if (m_alu_en && alu_en) begin
            check_val("alu_op", alu_op, m_op);
            check_val("alu_a", alu_a, m_a);
            check_val("alu_b", alu_b, m_b);
        end
        for (int i = 0; i < N; i++) begin
            if (req_rdy[i]) begin
                obs_log.push_back(i);
                obs_ngrant++;
            end
        end
        // Bench ALU: result appears LAT cycles after the issue strobe.
        if (alu_en) alu_sched[cyc + LAT] = alu_fn(alu_op, alu_a, alu_b);
        if (alu_sched.exists(cyc)) alu_sched.delete(cyc);
        m_alu_en = (g >= 0);
        if (g >= 0) begin
            m_op = req_op[g];
            m_a  = req_a[g];
            m_b  = req_b[g];
        end
        if (rs) begin
            mq.delete();
            m_ptr = N - 1; m_alu_en = 1'b0; m_op = '0; m_a = '0; m_b = '0;
        end else if (fl) begin
            mq.delete();
        end else begin
            if (rdy && exp_rv) void'(mq.pop_front());
            if (g >= 0) begin
                mq.push_back('{g, req_tag[g], alu_fn(req_op[g], req_a[g], req_b[g]), cyc + 4});
                m_ptr = g;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; req_vld = '0; res_rdy = 1'b0; alu_res = '0;
        req_op = '0; req_a = '0; req_b = '0; req_tag = '0;
        cyc = 0; keep_ops = 1'b0; obs_ngrant = 0;
        m_ptr = N - 1; m_alu_en = 1'b0; m_op = '0; m_a = '0; m_b = '0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state and a single op from requester 0.
        step(3'b000, 1'b1, 1'b0, 1'b0);
        keep_ops   = 1'b1;
        req_op[0]  = 13'h001; req_a[0] = 68'h1; req_b[0] = 68'h2; req_tag[0] = 9'd5;
        step(3'b001, 1'b1, 1'b0, 1'b0);
        keep_ops   = 1'b0;
        repeat (6) step(3'b000, 1'b1, 1'b0, 1'b0);

        // Fairness right after reset: 0,1,2,0,1,2.
        repeat (2) step(3'b000, 1'b1, 1'b0, 1'b1);
        obs_log.delete();
        repeat (8) step(3'b111, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            check_val("fair_order", (i < obs_log.size()) ? obs_log[i] : -1, i % 3);
        end

        // Backpressure: exactly DEPTH grants with no pops, then one per pop.
        repeat (8) step(3'b000, 1'b1, 1'b0, 1'b0);
        obs_ngrant = 0;
        repeat (10) step(3'b111, 1'b0, 1'b0, 1'b0);
        check_val("bp_grants", obs_ngrant, 4);
        repeat (8) step(3'b111, 1'b1, 1'b0, 1'b0);

        // Flush with two in flight and two buffered.
        repeat (8) step(3'b000, 1'b1, 1'b0, 1'b0);
        repeat (4) step(3'b111, 1'b0, 1'b0, 1'b0);
        step(3'b000, 1'b0, 1'b0, 1'b0);
        check_val("pre_flush_cnt", dut.fifo_cnt_s, 2);
        step(3'b000, 1'b1, 1'b1, 1'b0);
        repeat (6) step(3'b000, 1'b1, 1'b0, 1'b0);
        obs_ngrant = 0;
        repeat (4) step(3'b111, 1'b0, 1'b0, 1'b0);
        check_val("flush_credits", obs_ngrant, 4);

        // Same-cycle push and pop with three entries buffered.
        repeat (10) step(3'b000, 1'b1, 1'b0, 1'b0);
        repeat (4) step(3'b111, 1'b0, 1'b0, 1'b0);
        repeat (2) step(3'b000, 1'b0, 1'b0, 1'b0);
        step(3'b000, 1'b1, 1'b0, 1'b0);
        check_val("pushpop_cnt", dut.fifo_cnt_s, 3);
        repeat (8) step(3'b000, 1'b1, 1'b0, 1'b0);

        // Random traffic with random pops, flushes and the odd reset.
        repeat (1500) begin
            step(3'($urandom()), ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0);
        end
        repeat (10) step(3'b000, 1'b1, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
